mem_stage: RTL
==============

Name: mem_stage

Overview:
- Memory-access stage of the 5-stage pipeline. Sits between the EX/MEM register and the MEM/WB register.
- Non-memory instructions pass straight through with writeback info unchanged, same cycle.
- Loads and stores run a data-bus request/acknowledge transaction. The block stalls the pipeline until the transaction completes, and applies byte/halfword alignment, sign extension, misalignment detection and a bus timeout.

Parameters:
- TIMEOUT, 16, max cycles to wait for dbus_ack before aborting (≥2).
- CNT_W, 5, width of timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous active-high reset
- mem_wd  in  5  destination register address from EX/MEM
- mem_wreg  in  1  destination write enable from EX/MEM
- mem_wdata  in  32  ALU result from EX/MEM
- mem_aluop  in  8  operation code; load/store codes from shared package
- mem_addr  in  32  effective address (load/store only)
- mem_reg2  in  32  store data
- wb_wd  out  5  to MEM/WB: destination address
- wb_wreg  out  1  to MEM/WB: write enable
- wb_wdata  out  32  to MEM/WB: writeback value
- stallreq  out  1  to pipeline control: hold IF..MEM
- dbus_req  out  1  data bus request
- dbus_we  out  1  1 = write
- dbus_addr  out  32  word-aligned address (low 2 bits zero)
- dbus_be  out  4  byte enables; bit i = byte lane i, little-endian
- dbus_wdata  out  32  lane-replicated store data
- dbus_ack  in  1  transaction complete (one cycle)
- dbus_rdata  in  32  read data, valid with dbus_ack
- excpt_misalign  out  1  one-cycle pulse on misaligned access
- excpt_buserr  out  1  one-cycle pulse on timeout

Behaviour:
- Reset: asynchronous, active-high, applied on posedge rst. FSM goes to IDLE; counter = 0; rdata register = 0. All outputs are 0; wb_wd = 0 (NOP register).
- FSM states: IDLE, BUSY, DONE.
- IDLE, non-memory op:
  - wb_* = mem_* combinationally.
  - stallreq = 0, dbus_req = 0.
- IDLE, load/store op, misaligned (half with addr[0] = 1, word with addr[1:0] ≠ 0):
  - No bus access.
  - excpt_misalign = 1 this cycle; wb_wreg = 0; stallreq = 0.
  - Stay IDLE.
- IDLE, load/store op, aligned:
  - stallreq = 1; dbus_req = 1 combinationally in the same cycle.
  - Next state BUSY; counter cleared.
- BUSY:
  - dbus_req, we, addr, be, wdata are held stable; stallreq = 1; counter increments each cycle.
  - On dbus_ack: capture extracted load data into rdata register; next state DONE.
  - If counter reaches TIMEOUT-1 without ack: drop dbus_req next cycle, excpt_buserr = 1 for one cycle, wb_wreg forced 0; next state DONE.
- DONE:
  - stallreq = 0.
  - wb_wd = mem_wd (inputs still held by stall).
  - wb_wreg = mem_wreg for loads; 0 for stores and timeouts.
  - wb_wdata = rdata register.
  - Next state IDLE.
- An ack in the same cycle as dbus_req is allowed; latency is 1 cycle of BUSY minimum.
- Total stall for an access acked after k BUSY cycles: k+1 cycles.
- Byte enables:
  - SB: be = 1 << addr[1:0], wdata = {4{reg2[7:0]}}.
  - SH: be = 0011 or 1100, wdata = {2{reg2[15:0]}}.
  - SW: be = 1111.
  - Loads use the same be patterns.
- Load extraction: LB/LH sign-extend; LBU/LHU zero-extend; lane selected by addr[1:0].
- dbus_ack outside BUSY is ignored.
- Reset mid-transaction: dbus_req drops immediately; no writeback or exception is issued.

Decomposition:
- Shared package (existing defines file) holds:
  - aluop codes EXE_LB/LBU/LH/LHU/LW/SB/SH/SW_OP
  - NOPRegAddr, ZeroWord
  - state encodings MEM_IDLE/BUSY/DONE
- One sub-module: mem_align. Purely combinational: computes be, replicated wdata, misalign flag, and extracted/extended load data from aluop, addr[1:0], reg2 and rdata.

Test Plan:
- ADD result 0x1234 to r5 passes through → same cycle wb_wd = 5, wb_wreg = 1, wb_wdata = 0x1234, stallreq = 0, dbus_req = 0.
- LB addr 0x103, ack after 2 BUSY cycles with rdata 0x80FFFFFF → be = 1000; stallreq high for 3 cycles; DONE gives wb_wdata = 0xFFFFFF80. LBU in the same setup gives 0x00000080.
- SH addr 0x102, reg2 = 0xDEADBEEF → dbus_we = 1, be = 1100, wdata = 0xBEEFBEEF; DONE wb_wreg = 0.
- LW addr 0x101 → excpt_misalign pulse; dbus_req never asserted; wb_wreg = 0; no stall.
- LW with ack never given, TIMEOUT = 16 → dbus_req high exactly 16 cycles; excpt_buserr one-cycle pulse; wb_wreg = 0; FSM returns to IDLE.
- rst pulsed asynchronously (mid-clock) during BUSY → dbus_req and stallreq fall before the next clk edge; a following ADD passes through normally.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: load/store opcodes, reset values
// and the access state encoding.
package mem_stage_pkg;

   localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
   localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
   localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
   localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
   localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
   localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
   localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
   localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

   localparam logic [4:0]  NOPRegAddr = 5'b00000;
   localparam logic [31:0] ZeroWord   = 32'h0000_0000;

   typedef enum logic [1:0] {
      MEM_IDLE = 2'd0,
      MEM_BUSY = 2'd1,
      MEM_DONE = 2'd2
   } mem_state_e;

endpackage

// File: rtl/mem_align.sv
// Combinational byte-lane logic: byte enables, lane-replicated store data,
// misalignment detection and load data extraction with sign/zero extension.
module mem_align
   import mem_stage_pkg::*;
(
   input  logic [7:0]  aluop,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] reg2,
   input  logic [31:0] rdata,
   output logic        is_load,
   output logic        is_store,
   output logic        misalign,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] ldata
);

   logic [7:0]  rd_byte;
   logic [15:0] rd_half;

   assign rd_byte = rdata[{addr_lo, 3'b000} +: 8];
   assign rd_half = rdata[{addr_lo[1], 4'b0000} +: 16];

   always_comb begin
      is_load  = 1'b0;
      is_store = 1'b0;
      misalign = 1'b0;
      be       = 4'b0000;
      wdata    = ZeroWord;
      ldata    = ZeroWord;
      case (aluop)
         EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: begin
            be    = 4'b0001 << addr_lo;
            wdata = {4{reg2[7:0]}};
         end
         EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: begin
            be       = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata    = {2{reg2[15:0]}};
            misalign = addr_lo[0];
         end
         EXE_LW_OP, EXE_SW_OP: begin
            be       = 4'b1111;
            wdata    = reg2;
            misalign = |addr_lo;
         end
         default: ;
      endcase
      case (aluop)
         EXE_LB_OP:  begin is_load = 1'b1; ldata = {{24{rd_byte[7]}}, rd_byte};  end
         EXE_LBU_OP: begin is_load = 1'b1; ldata = {24'h000000, rd_byte};       end
         EXE_LH_OP:  begin is_load = 1'b1; ldata = {{16{rd_half[15]}}, rd_half}; end
         EXE_LHU_OP: begin is_load = 1'b1; ldata = {16'h0000, rd_half};         end
         EXE_LW_OP:  begin is_load = 1'b1; ldata = rdata;                       end
         EXE_SB_OP, EXE_SH_OP, EXE_SW_OP: is_store = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: passes non-memory ops through and runs a stalled
// request/acknowledge bus transaction with timeout for loads and stores.
//
//   state    | meaning
//   MEM_IDLE | pass-through; launches aligned accesses, flags misaligned ones
//   MEM_BUSY | request held on the bus, waiting for ack or timeout
//   MEM_DONE | stall released, load result (or nothing) written back
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  mem_wd,
   input  logic        mem_wreg,
   input  logic [31:0] mem_wdata,
   input  logic [7:0]  mem_aluop,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_reg2,
   output logic [4:0]  wb_wd,
   output logic        wb_wreg,
   output logic [31:0] wb_wdata,
   output logic        stallreq,
   output logic        dbus_req,
   output logic        dbus_we,
   output logic [31:0] dbus_addr,
   output logic [3:0]  dbus_be,
   output logic [31:0] dbus_wdata,
   input  logic        dbus_ack,
   input  logic [31:0] dbus_rdata,
   output logic        excpt_misalign,
   output logic        excpt_buserr
);

   mem_state_e        state, state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [31:0]       rdata_q;
   logic              tmo_q;

   logic              is_load, is_store, misalign;
   logic [3:0]        lane_be;
   logic [31:0]       lane_wdata, ldata;
   logic              timeout_hit;

   mem_align u_align (
      .aluop    (mem_aluop),
      .addr_lo  (mem_addr[1:0]),
      .reg2     (mem_reg2),
      .rdata    (dbus_rdata),
      .is_load  (is_load),
      .is_store (is_store),
      .misalign (misalign),
      .be       (lane_be),
      .wdata    (lane_wdata),
      .ldata    (ldata)
   );

   // The launch cycle in IDLE also carries the request, so the bus sees
   // TIMEOUT request cycles when BUSY gives up at count TIMEOUT-2.
   assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 2));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= MEM_IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= '0;
         rdata_q <= ZeroWord;
         tmo_q   <= 1'b0;
      end else begin
         case (state)
            MEM_IDLE: cnt <= '0;
            MEM_BUSY: begin
               cnt   <= cnt + CNT_W'(1);
               tmo_q <= ~dbus_ack;
               if (dbus_ack) rdata_q <= ldata;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt      = state;
      wb_wd          = mem_wd;
      wb_wreg        = 1'b0;
      wb_wdata       = mem_wdata;
      stallreq       = 1'b0;
      dbus_req       = 1'b0;
      excpt_misalign = 1'b0;
      excpt_buserr   = 1'b0;
      if (rst) begin
         wb_wd    = NOPRegAddr;
         wb_wdata = ZeroWord;
      end else begin
         case (state)
            MEM_IDLE: begin
               if (!(is_load || is_store)) begin
                  wb_wreg = mem_wreg;
               end else if (misalign) begin
                  excpt_misalign = 1'b1;
               end else begin
                  stallreq  = 1'b1;
                  dbus_req  = 1'b1;
                  state_nxt = MEM_BUSY;
               end
            end
            MEM_BUSY: begin
               stallreq = 1'b1;
               dbus_req = 1'b1;
               if (dbus_ack || timeout_hit) state_nxt = MEM_DONE;
            end
            MEM_DONE: begin
               wb_wreg      = is_load & mem_wreg & ~tmo_q;
               wb_wdata     = rdata_q;
               excpt_buserr = tmo_q;
               state_nxt    = MEM_IDLE;
            end
            default: state_nxt = MEM_IDLE;
         endcase
      end
   end

   assign dbus_we    = dbus_req & is_store;
   assign dbus_addr  = dbus_req ? {mem_addr[31:2], 2'b00} : ZeroWord;
   assign dbus_be    = dbus_req ? lane_be : 4'b0000;
   assign dbus_wdata = dbus_req ? lane_wdata : ZeroWord;

endmodule
